mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory port between fetch and load/store.
// Optional wait-state watchdog enabled with the ARBITER_TIMEOUT_EN macro.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_instReq,
  input  logic [ADDR_WIDTH-1:0] i_instAddr,
  output logic [DATA_WIDTH-1:0] o_instData,
  output logic                  o_instAck,
  input  logic                  i_dataReq,
  input  logic [ADDR_WIDTH-1:0] i_dataAddr,
  input  logic                  i_dataWrEnable,
  input  logic [DATA_WIDTH-1:0] i_dataWrData,
  input  logic [1:0]            i_dataAccess,
  output logic [DATA_WIDTH-1:0] o_dataRdData,
  output logic                  o_dataAck,
  output logic [ADDR_WIDTH-1:0] o_memAddr,
  output logic                  o_memRdEnable,
  output logic                  o_memWrEnable,
  output logic [DATA_WIDTH-1:0] o_memWrData,
  output logic [1:0]            o_memAccess,
  input  logic [DATA_WIDTH-1:0] i_memRdData,
  input  logic                  i_memReady,
  output logic                  o_error
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  state_t                state;
  logic                  last_data;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;
  logic [1:0]            acc_q;

  logic inst_elig;
  logic data_elig;
  logic pick_data;
  logic expired;

  // A port is not eligible in the cycle its own ack is showing.
  assign inst_elig = i_instReq & ~o_instAck;
  assign data_elig = i_dataReq & ~o_dataAck;
  assign pick_data = data_elig & (~inst_elig | ~last_data);

`ifdef ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
  assign expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  // Without the watchdog a busy access never expires.
  assign expired = (TIMEOUT_CYCLES < 0);
`endif

  // Memory strobes follow the owning state and the latched direction.
  assign o_memRdEnable = (state == BUSY_I) | ((state == BUSY_D) & ~we_q);
  assign o_memWrEnable = (state == BUSY_D) & we_q;
  assign o_memAddr     = addr_q;
  assign o_memWrData   = wdata_q;
  assign o_memAccess   = acc_q;

  // Arbitration FSM: grant, wait for the memory, then pulse the ack.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= IDLE;
      last_data    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      acc_q        <= 2'b00;
      o_instAck    <= 1'b0;
      o_dataAck    <= 1'b0;
      o_error      <= 1'b0;
      o_instData   <= '0;
      o_dataRdData <= '0;
`ifdef ARBITER_TIMEOUT_EN
      wait_cnt     <= '0;
`endif
    end else begin
      o_instAck <= 1'b0;
      o_dataAck <= 1'b0;
      o_error   <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_elig | data_elig) begin
            last_data <= pick_data;
            state     <= pick_data ? BUSY_D : BUSY_I;
            addr_q    <= pick_data ? i_dataAddr : i_instAddr;
            wdata_q   <= pick_data ? i_dataWrData : '0;
            we_q      <= pick_data & i_dataWrEnable;
            acc_q     <= pick_data ? i_dataAccess : 2'b10;
`ifdef ARBITER_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        BUSY_I, BUSY_D: begin
          if (i_memReady) begin
            if (state == BUSY_I) begin
              o_instData <= i_memRdData;
              o_instAck  <= 1'b1;
            end else begin
              if (!we_q) o_dataRdData <= i_memRdData;
              o_dataAck <= 1'b1;
            end
            state <= IDLE;
          end else if (expired) begin
            if (state == BUSY_I) begin
              o_instData <= '0;
              o_instAck  <= 1'b1;
            end else begin
              o_dataRdData <= '0;
              o_dataAck    <= 1'b1;
            end
            o_error <= 1'b1;
            state   <= IDLE;
          end else begin
`ifdef ARBITER_TIMEOUT_EN
            wait_cnt <= wait_cnt + CW'(1);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        iack;
  logic        dreq;
  logic [31:0] daddr;
  logic        dwe;
  logic [31:0] dwd;
  logic [1:0]  dacc;
  logic [31:0] drd;
  logic        dack;
  logic [31:0] maddr;
  logic        mrd;
  logic        mwr;
  logic [31:0] mwd;
  logic [1:0]  macc;
  logic [31:0] mrdata;
  logic        mready;
  logic        err;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_instReq     (ireq),
    .i_instAddr    (iaddr),
    .o_instData    (idata),
    .o_instAck     (iack),
    .i_dataReq     (dreq),
    .i_dataAddr    (daddr),
    .i_dataWrEnable(dwe),
    .i_dataWrData  (dwd),
    .i_dataAccess  (dacc),
    .o_dataRdData  (drd),
    .o_dataAck     (dack),
    .o_memAddr     (maddr),
    .o_memRdEnable (mrd),
    .o_memWrEnable (mwr),
    .o_memWrData   (mwd),
    .o_memAccess   (macc),
    .i_memRdData   (mrdata),
    .i_memReady    (mready),
    .o_error       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: owner 0 = none, 1 = fetch, 2 = data transaction.
  int          m_own;
  bit          m_last_d;
  int          m_wait;
  bit [31:0]   m_addr;
  bit [31:0]   m_wd;
  bit          m_we;
  bit [1:0]    m_acc;
  bit          m_iack;
  bit          m_dack;
  bit          m_err;
  bit [31:0]   m_idata;
  bit [31:0]   m_ddata;

  task automatic finish_txn(input bit timed_out);
    if (m_own == 1) begin
      m_idata = timed_out ? 32'h0 : mrdata;
      m_iack  = 1'b1;
    end else begin
      if (timed_out) m_ddata = 32'h0;
      else if (!m_we) m_ddata = mrdata;
      m_dack = 1'b1;
    end
    m_err = timed_out;
    m_own = 0;
  endtask

  task automatic model_step();
    bit ei;
    bit ed;
    int pick;
    ei = ireq && !m_iack;
    ed = dreq && !m_dack;
    m_iack = 1'b0;
    m_dack = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_own = 0; m_last_d = 0; m_wait = 0;
      m_addr = 0; m_wd = 0; m_we = 0; m_acc = 0;
      m_idata = 0; m_ddata = 0;
    end else if (m_own == 0) begin
      pick = 0;
      if (ei && ed) pick = m_last_d ? 1 : 2;
      else if (ed) pick = 2;
      else if (ei) pick = 1;
      if (pick != 0) begin
        m_own    = pick;
        m_last_d = (pick == 2);
        m_wait   = 0;
        m_addr   = (pick == 2) ? daddr : iaddr;
        m_we     = (pick == 2) && dwe;
        m_wd     = dwd;
        m_acc    = (pick == 2) ? dacc : 2'b10;
      end
    end else if (mready) begin
      finish_txn(1'b0);
    end else begin
      m_wait++;
`ifdef ARBITER_TIMEOUT_EN
      if (m_wait == TO) finish_txn(1'b1);
`endif
    end
  endtask

  // Advance one clock, update the model, and compare every output.
  task automatic cycle();
    bit e_rd;
    bit e_wr;
    @(posedge clk);
    #1;
    model_step();
    e_rd = (m_own == 1) || (m_own == 2 && !m_we);
    e_wr = (m_own == 2) && m_we;
    check("inst_ack", iack, m_iack);
    check("data_ack", dack, m_dack);
    check("error", err, m_err);
    check("inst_data", idata, m_idata);
    check("data_rd", drd, m_ddata);
    check("mem_rd", mrd, e_rd);
    check("mem_wr", mwr, e_wr);
    check("mem_addr", maddr, m_addr);
    if (e_wr) check("mem_wdata", mwd, m_wd);
    if (e_rd || e_wr) check("mem_access", macc, m_acc);
  endtask

  int wr_cnt;
  int acks;
  int errs;
  int ack_at;

  initial begin
    rst = 1; ireq = 0; dreq = 0; iaddr = 0; daddr = 0;
    dwe = 0; dwd = 0; dacc = 0; mrdata = 0; mready = 0;
    cycle();
    cycle();
    check("reset_strobe", mrd | mwr, 1'b0);
    check("reset_acks", iack | dack | err, 1'b0);
    check("reset_data", idata | drd, 32'h0);
    rst = 0;
    cycle();

    // Zero-wait fetch.
    ireq = 1; iaddr = 32'h100; mready = 1; mrdata = 32'h00500093;
    cycle();
    check("t1_strobe", mrd, 1'b1);
    check("t1_addr", maddr, 32'h100);
    check("t1_access", macc, 2'b10);
    cycle();
    check("t1_ack", iack, 1'b1);
    check("t1_data", idata, 32'h00500093);
    ireq = 0; mready = 0;
    cycle();
    check("t1_pulse", iack, 1'b0);

    // Store with two wait states.
    dreq = 1; dwe = 1; daddr = 32'h2000; dwd = 32'hDEADBEEF; dacc = 2'b10;
    wr_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      wr_cnt += int'(mwr);
      mready = (k == 2);
    end
    cycle();
    check("t2_wr_cycles", wr_cnt, 3);
    check("t2_ack", dack, 1'b1);
    check("t2_rd_kept", drd, 32'h0);
    dreq = 0; mready = 0;
    cycle();

    // Contention from reset release: data first, then fetch.
    rst = 1; ireq = 1; dreq = 1; dwe = 0;
    iaddr = 32'h40; daddr = 32'h3000; mready = 1; mrdata = 32'h55;
    cycle();
    rst = 0;
    cycle();
    check("t3_first_d", maddr, 32'h3000);
    cycle();
    check("t3_d_ack", dack, 1'b1);
    cycle();
    check("t3_second_i", maddr, 32'h40);
    check("t3_i_strobe", mrd, 1'b1);
    for (int k = 0; k < 12; k++) cycle();
    ireq = 0; dreq = 0; mready = 0;

    // Reset during a load abandons it.
    rst = 1;
    cycle();
    rst = 0; dreq = 1; dwe = 0; daddr = 32'h80;
    cycle();
    check("t4_busy", mrd, 1'b1);
    rst = 1;
    cycle();
    check("t4_rst_strobe", mrd, 1'b0);
    rst = 0; dreq = 0;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      acks += int'(dack);
    end
    check("t4_no_ack", acks, 0);
    dreq = 1; mrdata = 32'h1234; mready = 1;
    cycle();
    cycle();
    check("t4_fresh_ack", dack, 1'b1);
    check("t4_fresh_data", drd, 32'h1234);
    dreq = 0;

    // Back-to-back fetches; the re-request waits a cycle after the ack.
    ireq = 1; iaddr = 32'h0; mrdata = 32'h11;
    cycle();
    cycle();
    check("t5_ack0", iack, 1'b1);
    iaddr = 32'h4; mrdata = 32'h22;
    cycle();
    check("t5_gap", mrd, 1'b0);
    cycle();
    check("t5_addr1", maddr, 32'h4);
    cycle();
    check("t5_ack1", iack, 1'b1);
    check("t5_data1", idata, 32'h22);
    ireq = 0; mready = 0;
    cycle();

    // Memory never ready.
    ireq = 1; iaddr = 32'h500; mrdata = 32'hFFFFFFFF;
    acks = 0; errs = 0; ack_at = -1;
    for (int k = 0; k < 24; k++) begin
      cycle();
      if (iack) begin
        acks++;
        errs += int'(err);
        ack_at = k;
        ireq = 0;
      end
    end
`ifdef ARBITER_TIMEOUT_EN
    check("t6_acks", acks, 1);
    check("t6_err", errs, 1);
    check("t6_when", ack_at, TO);
    check("t6_data", idata, 32'h0);
`else
    check("t6_no_ack", acks, 0);
    check("t6_still_busy", mrd, 1'b1);
`endif
    ireq = 0;
    rst = 1;
    cycle();
    rst = 0;

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      cycle();
      if (!ireq || m_iack) ireq = ($urandom_range(99) < 55);
      if (!dreq || m_dack) dreq = ($urandom_range(99) < 55);
      iaddr  = $urandom;
      daddr  = $urandom;
      dwd    = $urandom;
      dwe    = $urandom_range(1);
      dacc   = 2'($urandom_range(3));
      mrdata = $urandom;
      mready = ($urandom_range(99) < 60);
      rst    = ($urandom_range(249) == 0);
    end
    rst = 0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
